// File: rtl/map_table.sv
// Register-rename map table.
// Each architectural register records the ROB tag of its youngest in-flight
// producer and whether that producer has already broadcast on the CDB.
// Source lookups are combinational and show the state before this cycle's
// updates. Dispatch, CDB, retire and squash update the table at the clock edge.
// Handshake semantics: every *_valid input is a single-cycle qualifier sampled
// at the rising edge. The table never pushes back, so there is no ready
// handshake. stall only qualifies dispatch.
module map_table #(
    parameter int ARCH_REGS = 32,
    parameter int ROB_LEN   = 8,
    parameter int TAG_W     = $clog2(ROB_LEN),
    parameter int REG_W     = $clog2(ARCH_REGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             dp_valid,
    input  logic [REG_W-1:0] dp_dest_idx,
    input  logic [TAG_W-1:0] dp_tag,
    input  logic [REG_W-1:0] rs1_idx,
    input  logic [REG_W-1:0] rs2_idx,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic             rt_valid,
    input  logic [TAG_W-1:0] rt_tag,
    input  logic [REG_W-1:0] rt_dest_idx,
    input  logic             squash,
    output logic             rs1_mapped,
    output logic [TAG_W-1:0] rs1_tag,
    output logic             rs1_ready,
    output logic             rs2_mapped,
    output logic [TAG_W-1:0] rs2_tag,
    output logic             rs2_ready,
    output logic [REG_W:0]   mapped_cnt
);

    logic [ARCH_REGS-1:0] mapped_q;
    logic [ARCH_REGS-1:0] ready_q;
    logic [TAG_W-1:0]     tag_q [ARCH_REGS];

    logic [ARCH_REGS-1:0] mapped_d;
    logic [ARCH_REGS-1:0] ready_d;
    logic [TAG_W-1:0]     tag_d [ARCH_REGS];
    logic [REG_W:0]       cnt_q;
    logic [REG_W:0]       cnt_d;

    logic dp_en;
    logic rt_hit;
    logic cnt_inc;
    logic cnt_dec;

    // Qualify dispatch and retire. Retire only frees a register whose
    // current owner is the retiring tag.
    always_comb begin
        dp_en  = dp_valid && !stall && !squash && (dp_dest_idx != '0);
        rt_hit = rt_valid && (rt_dest_idx != '0) && mapped_q[rt_dest_idx]
                 && (tag_q[rt_dest_idx] == rt_tag);
        cnt_inc = dp_en && !mapped_q[dp_dest_idx];
        // A dispatch to the retiring register keeps it mapped, so the count holds.
        cnt_dec = rt_hit && !(dp_en && (dp_dest_idx == rt_dest_idx));
    end

    // Next-state table. Priority from lowest to highest: CDB, retire, dispatch, squash.
    always_comb begin
        mapped_d = mapped_q;
        ready_d  = ready_q;
        tag_d    = tag_q;
        for (int r = 1; r < ARCH_REGS; r++) begin
            if (cdb_valid && mapped_q[r] && (tag_q[r] == cdb_tag)) begin
                ready_d[r] = 1'b1;
            end
            if (rt_hit && (rt_dest_idx == REG_W'(r))) begin
                mapped_d[r] = 1'b0;
                ready_d[r]  = 1'b0;
            end
            if (dp_en && (dp_dest_idx == REG_W'(r))) begin
                mapped_d[r] = 1'b1;
                ready_d[r]  = 1'b0;
                tag_d[r]    = dp_tag;
            end
            if (squash) begin
                mapped_d[r] = 1'b0;
                ready_d[r]  = 1'b0;
                tag_d[r]    = '0;
            end
        end
        // Register zero is hardwired and never holds a mapping.
        mapped_d[0] = 1'b0;
        ready_d[0]  = 1'b0;
        tag_d[0]    = '0;
    end

    // Population counter of mapped registers, cleared on squash.
    always_comb begin
        cnt_d = cnt_q;
        if (squash) begin
            cnt_d = '0;
        end else if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mapped_q <= '0;
            ready_q  <= '0;
            cnt_q    <= '0;
            for (int r = 0; r < ARCH_REGS; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            mapped_q <= mapped_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
            for (int r = 0; r < ARCH_REGS; r++) begin
                tag_q[r] <= tag_d[r];
            end
        end
    end

    // Zero-latency source lookups with a CDB bypass on the ready bit.
    always_comb begin
        rs1_mapped = 1'b0;
        rs1_tag    = '0;
        rs1_ready  = 1'b0;
        rs2_mapped = 1'b0;
        rs2_tag    = '0;
        rs2_ready  = 1'b0;
        if ((rs1_idx != '0) && mapped_q[rs1_idx]) begin
            rs1_mapped = 1'b1;
            rs1_tag    = tag_q[rs1_idx];
            rs1_ready  = ready_q[rs1_idx] || (cdb_valid && (cdb_tag == tag_q[rs1_idx]));
        end
        if ((rs2_idx != '0) && mapped_q[rs2_idx]) begin
            rs2_mapped = 1'b1;
            rs2_tag    = tag_q[rs2_idx];
            rs2_ready  = ready_q[rs2_idx] || (cdb_valid && (cdb_tag == tag_q[rs2_idx]));
        end
    end

    assign mapped_cnt = cnt_q;

endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table with a short random dispatch phase.
// Expected lookup words are pushed when a step is driven and popped when the
// outputs are sampled 1 ns later, mid clock-low phase.
module tb_map_table;

    localparam int TAG_W = 3;
    localparam int REG_W = 5;
    localparam int EXP_W = 2 * (TAG_W + 2) + REG_W + 1;

    logic             clock;
    logic             reset;
    logic             stall;
    logic             dp_valid;
    logic [REG_W-1:0] dp_dest_idx;
    logic [TAG_W-1:0] dp_tag;
    logic [REG_W-1:0] rs1_idx;
    logic [REG_W-1:0] rs2_idx;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             rt_valid;
    logic [TAG_W-1:0] rt_tag;
    logic [REG_W-1:0] rt_dest_idx;
    logic             squash;
    logic             rs1_mapped;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_ready;
    logic             rs2_mapped;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_ready;
    logic [REG_W:0]   mapped_cnt;

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic             m_mapped [32];
    logic [TAG_W-1:0] m_tag    [32];
    int               m_cnt;

    map_table dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .dp_valid    (dp_valid),
        .dp_dest_idx (dp_dest_idx),
        .dp_tag      (dp_tag),
        .rs1_idx     (rs1_idx),
        .rs2_idx     (rs2_idx),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .rt_valid    (rt_valid),
        .rt_tag      (rt_tag),
        .rt_dest_idx (rt_dest_idx),
        .squash      (squash),
        .rs1_mapped  (rs1_mapped),
        .rs1_tag     (rs1_tag),
        .rs1_ready   (rs1_ready),
        .rs2_mapped  (rs2_mapped),
        .rs2_tag     (rs2_tag),
        .rs2_ready   (rs2_ready),
        .mapped_cnt  (mapped_cnt)
    );

    // Clock: 10 ns period, rising edges at 5, 15, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive_idle();
        stall       = 1'b0;
        dp_valid    = 1'b0;
        dp_dest_idx = '0;
        dp_tag      = '0;
        rs1_idx     = '0;
        rs2_idx     = '0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        rt_valid    = 1'b0;
        rt_tag      = '0;
        rt_dest_idx = '0;
        squash      = 1'b0;
    endtask

    // Advance to the next falling edge and clear all strobes.
    task automatic next_cycle();
        @(negedge clock);
        drive_idle();
    endtask

    task automatic dispatch(input logic [REG_W-1:0] d, input logic [TAG_W-1:0] t);
        dp_valid    = 1'b1;
        dp_dest_idx = d;
        dp_tag      = t;
    endtask

    task automatic retire(input logic [REG_W-1:0] d, input logic [TAG_W-1:0] t);
        rt_valid    = 1'b1;
        rt_dest_idx = d;
        rt_tag      = t;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t);
        cdb_valid = 1'b1;
        cdb_tag   = t;
    endtask

    // Push the expected lookup word, let the combinational outputs settle, pop and compare.
    task automatic check_step(input string name,
                              input logic e1m, input logic [TAG_W-1:0] e1t, input logic e1r,
                              input logic e2m, input logic [TAG_W-1:0] e2t, input logic e2r,
                              input int ecnt);
        logic [EXP_W-1:0] obs;
        logic [EXP_W-1:0] exp_w;
        exp_q.push_back({e1m, e1t, e1r, e2m, e2t, e2r, (REG_W + 1)'(ecnt)});
        #1;
        obs   = {rs1_mapped, rs1_tag, rs1_ready, rs2_mapped, rs2_tag, rs2_ready, mapped_cnt};
        exp_w = exp_q.pop_front();
        checks++;
        assert (obs === exp_w) else begin
            errors++;
            $error("FAIL %s: observed m1/t1/r1/m2/t2/r2/cnt=%b/%0d/%b/%b/%0d/%b/%0d expected %b/%0d/%b/%b/%0d/%b/%0d",
                   name, obs[15], obs[14:12], obs[11], obs[10], obs[9:7], obs[6], obs[5:0],
                   exp_w[15], exp_w[14:12], exp_w[11], exp_w[10], exp_w[9:7], exp_w[6], exp_w[5:0]);
        end
    endtask

    initial begin
        int r;
        int t;
        drive_idle();
        reset = 1'b0;
        rs1_idx = 5'd5;
        #2;
        check_step("reset_held", 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Reset state after release.
        next_cycle();
        rs1_idx = 5'd5; rs2_idx = 5'd0;
        check_step("after_reset", 0, 0, 0, 0, 0, 0, 0);

        // Dispatch r3 tag 2, then the CDB bypass and a sticky ready bit.
        next_cycle();
        dispatch(5'd3, 3'd2); rs1_idx = 5'd3;
        check_step("dp_r3_same_cycle", 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rs1_idx = 5'd3;
        check_step("r3_mapped", 1, 2, 0, 0, 0, 0, 1);
        cdb(3'd2);
        check_step("r3_cdb_bypass", 1, 2, 1, 0, 0, 0, 1);
        next_cycle();
        rs1_idx = 5'd3;
        check_step("r3_ready_sticky", 1, 2, 1, 0, 0, 0, 1);

        // Overwrite r3 with tag 5; a stale retire of tag 2 leaves it alone.
        dispatch(5'd3, 3'd5);
        next_cycle();
        retire(5'd3, 3'd2); rs1_idx = 5'd3;
        check_step("r3_overwritten", 1, 5, 0, 0, 0, 0, 1);
        next_cycle();
        rs1_idx = 5'd3;
        check_step("stale_retire_ignored", 1, 5, 0, 0, 0, 0, 1);
        retire(5'd3, 3'd5);
        next_cycle();
        rs1_idx = 5'd3;
        check_step("r3_retired", 0, 0, 0, 0, 0, 0, 0);

        // r7 with a completed tag 1, then a same-cycle redispatch.
        dispatch(5'd7, 3'd1);
        next_cycle();
        cdb(3'd1);
        next_cycle();
        dispatch(5'd7, 3'd4); rs1_idx = 5'd7;
        check_step("r7_lookup_pre_dispatch", 1, 1, 1, 0, 0, 0, 1);
        next_cycle();
        rs1_idx = 5'd7;
        check_step("r7_post_dispatch", 1, 4, 0, 0, 0, 0, 1);

        // Dispatch beats CDB on the same register.
        dispatch(5'd7, 3'd3); cdb(3'd4); rs1_idx = 5'd7;
        check_step("r7_bypass_with_dispatch", 1, 4, 1, 0, 0, 0, 1);
        next_cycle();
        rs1_idx = 5'd7;
        check_step("dispatch_beats_cdb", 1, 3, 0, 0, 0, 0, 1);

        // CDB and retire on the same entry: it is cleared.
        cdb(3'd3); retire(5'd7, 3'd3); rs1_idx = 5'd7;
        check_step("r7_cdb_and_retire", 1, 3, 1, 0, 0, 0, 1);
        next_cycle();
        rs1_idx = 5'd7;
        check_step("cdb_retire_clears", 0, 0, 0, 0, 0, 0, 0);

        // Dispatch beats retire on the same register.
        dispatch(5'd10, 3'd0);
        next_cycle();
        dispatch(5'd10, 3'd7); retire(5'd10, 3'd0); rs1_idx = 5'd10;
        check_step("r10_pre", 1, 0, 0, 0, 0, 0, 1);
        next_cycle();
        rs1_idx = 5'd10;
        check_step("dispatch_beats_retire", 1, 7, 0, 0, 0, 0, 1);

        // Retire one register and map another in the same cycle: count is net zero.
        retire(5'd10, 3'd7); dispatch(5'd11, 3'd2);
        next_cycle();
        rs1_idx = 5'd10; rs2_idx = 5'd11;
        check_step("retire_plus_dispatch", 0, 0, 0, 1, 2, 0, 1);

        // Build r1, r2, r4, then squash together with a dispatch to r6.
        retire(5'd11, 3'd2); dispatch(5'd1, 3'd1);
        next_cycle();
        dispatch(5'd2, 3'd3);
        next_cycle();
        dispatch(5'd4, 3'd5);
        next_cycle();
        rs1_idx = 5'd2; rs2_idx = 5'd4;
        check_step("three_mapped", 1, 3, 0, 1, 5, 0, 3);
        squash = 1'b1; dispatch(5'd6, 3'd6); rs1_idx = 5'd1; rs2_idx = 5'd4;
        check_step("squash_cycle_lookup", 1, 1, 0, 1, 5, 0, 3);
        next_cycle();
        rs1_idx = 5'd6; rs2_idx = 5'd1;
        check_step("after_squash", 0, 0, 0, 0, 0, 0, 0);

        // Register zero is never mapped; stall blocks dispatch.
        dispatch(5'd0, 3'd3); rs1_idx = 5'd0;
        check_step("r0_lookup", 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        stall = 1'b1; dispatch(5'd9, 3'd2); rs1_idx = 5'd0;
        check_step("r0_not_mapped", 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rs1_idx = 5'd9;
        check_step("stall_blocks_dispatch", 0, 0, 0, 0, 0, 0, 0);

        // CDB still acts during a stall.
        dispatch(5'd9, 3'd2);
        next_cycle();
        stall = 1'b1; cdb(3'd2); dispatch(5'd12, 3'd1);
        next_cycle();
        rs1_idx = 5'd9; rs2_idx = 5'd12;
        check_step("cdb_during_stall", 1, 2, 1, 0, 0, 0, 1);

        // Asynchronous reset mid-operation clears outputs before any edge.
        #1;
        reset = 1'b0;
        check_step("async_reset", 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        reset = 1'b1;

        // Random dispatches against a small reference model.
        for (int i = 0; i < 32; i++) begin
            m_mapped[i] = 1'b0;
            m_tag[i]    = '0;
        end
        m_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            r = $urandom_range(1, 31);
            t = $urandom_range(0, 7);
            dispatch(REG_W'(r), TAG_W'(t)); rs1_idx = REG_W'(r);
            check_step("rand_pre", m_mapped[r], m_tag[r], 0, 0, 0, 0, m_cnt);
            if (!m_mapped[r]) m_cnt++;
            m_mapped[r] = 1'b1;
            m_tag[r]    = TAG_W'(t);
            next_cycle();
            rs1_idx = REG_W'(r);
            check_step("rand_post", 1, TAG_W'(t), 0, 0, 0, 0, m_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/map_table.md
Name: map_table

Overview:
- Register-rename map table between decode/dispatch and the reservation stations.
- Per architectural register, holds the ROB tag of the youngest in-flight producer and whether that producer has completed on the CDB.
- Dispatch reads source mappings from it. It is updated by dispatch, by CDB broadcast, by ROB retire (head_idx/retire), and cleared by ROB squash.

Parameters:
- ARCH_REGS, 32, number of architectural registers; register 0 is hardwired zero and never mapped.
- ROB_LEN, 8, ROB entries; TAG_W = $clog2(ROB_LEN).
- REG_W, 5, architectural register index width; $clog2(ARCH_REGS).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline stall; blocks the dispatch update.
- dp_valid  in  1  instruction dispatching this cycle.
- dp_dest_idx  in  REG_W  destination architectural register.
- dp_tag  in  TAG_W  ROB entry allocated (the ROB tail).
- rs1_idx  in  REG_W  source 1 lookup index.
- rs2_idx  in  REG_W  source 2 lookup index.
- cdb_valid  in  1  CDB broadcast valid (the inverse of no_output).
- cdb_tag  in  TAG_W  completing ROB tag.
- rt_valid  in  1  ROB retiring its head this cycle.
- rt_tag  in  TAG_W  ROB head_idx being retired.
- rt_dest_idx  in  REG_W  destination of the retiring entry.
- squash  in  1  ROB mispredict squash.
- rs1_mapped  out  1  source 1 value is in flight in the ROB.
- rs1_tag  out  TAG_W  ROB tag for source 1; 0 when not mapped.
- rs1_ready  out  1  mapped producer has completed; read the value from the ROB.
- rs2_mapped, rs2_tag, rs2_ready  out  1/TAG_W/1  same as source 1, for source 2.
- mapped_cnt  out  REG_W+1  number of currently mapped registers (debug/perf).

Behaviour:
- State per register r: mapped[r], tag[r], ready[r]. mapped_cnt is a registered counter.
- Reset (reset==0, asynchronous): all mapped/tag/ready = 0; mapped_cnt = 0. All outputs therefore read 0 while reset is asserted.
- Lookup is combinational and zero-latency.
  - rsX_mapped = mapped[idx]; rsX_tag = mapped ? tag : 0.
  - rsX_ready = mapped & (ready[idx] | (cdb_valid & cdb_tag==tag[idx])). This CDB bypass is required.
  - Lookup reflects pre-update state: a dispatch in the same cycle never affects the same instruction's source lookup.
  - idx 0 always returns mapped=0, tag=0, ready=0.
- Dispatch write: when dp_valid & !stall & !squash & dp_dest_idx!=0, at the next edge set mapped=1, tag=dp_tag, ready=0. This overwrites any older mapping.
- CDB: for every r with mapped[r] & tag[r]==cdb_tag & cdb_valid, set ready[r]=1 at the next edge. Multiple registers can never share a live tag; there is no requirement to detect it.
- Retire: if rt_valid & rt_dest_idx!=0 & mapped[rt_dest_idx] & tag[rt_dest_idx]==rt_tag, clear mapped/ready. If the tag differs, a younger producer owns the register and the entry is untouched.
- Simultaneous events on the same register:
  - Dispatch beats retire: the new mapping remains.
  - Dispatch beats CDB: ready=0.
  - CDB on an entry being retired: the entry is cleared.
- Squash: at the next edge clear every mapped/ready/tag and set mapped_cnt=0. Squash overrides dispatch, CDB and retire in that cycle. Lookups during the squash cycle still show pre-squash state.
- mapped_cnt tracks the population count of mapped. Increment only when dispatch maps a previously unmapped register; decrement when retire clears an entry. Both in one cycle on different registers gives net 0. Range is 0..ARCH_REGS-1; no wrap is possible.
- stall only gates dispatch; CDB, retire and squash act during stall.
- Tag width wraps naturally with ROB indices; the table performs no arithmetic on tags.

Test Plan:
- Reset release, then lookup rs1=5, rs2=0 -> mapped=0, tag=0, ready=0, mapped_cnt=0.
- Dispatch dest=3 tag=2. Next cycle lookup rs1=3 -> mapped=1, tag=2, ready=0. Then cdb_valid tag=2 -> same-cycle rs1_ready=1; the following cycle ready stays 1.
- Dispatch r3 tag=2, then r3 tag=5. Retire tag=2 dest=3 -> r3 still mapped tag=5, mapped_cnt=1. Retire tag=5 -> unmapped, cnt=0.
- Same cycle: dispatch r7 tag=4 and lookup rs1=7 (previously tag=1, ready=1) -> outputs tag=1, ready=1. Next cycle -> tag=4, ready=0.
- Map r1, r2, r4 (cnt=3); squash asserted together with dispatch r6 -> next cycle all unmapped, cnt=0, r6 not mapped.
- dp_dest_idx=0 dispatch, and stall=1 dispatch of r9 -> no mapping, cnt unchanged. Assert reset mid-operation with r9 mapped -> outputs clear immediately, without waiting for a clock edge.
